// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Sequencing controller for the 5-stage pipeline. Produces the register
//   enables, flushes and the MEM/WB bubble for load-use hazards, taken
//   branches and multi-cycle data-memory accesses. Owns the data-memory
//   request, force-completes hung accesses after TIMEOUT wait cycles, and
//   keeps a saturating count of stalled cycles.
//
// Ports
//   clk             in   pipeline clock, rising edge
//   reset           in   asynchronous active-high reset
//   idex_memRead    in   instruction in EX is a load
//   idex_rt[4:0]    in   destination register of the load in EX
//   ifid_rs[4:0]    in   source register rs of the instruction in ID
//   ifid_rt[4:0]    in   source register rt of the instruction in ID
//   branch_taken    in   taken branch/jump resolved in EX
//   exmem_memAccess in   instruction in MEM is a load or store
//   mem_ready       in   data memory completes the access this cycle
//   mem_req         out  data-memory request
//   pc_en           out  PC load enable
//   ifid_en         out  IF/ID load enable
//   exmem_en        out  EX/MEM load enable
//   ifid_flush      out  IF/ID loads a NOP on the next edge
//   idex_flush      out  ID/EX loads zero control on the next edge
//   memwb_bubble    out  MEM/WB loads zero control bits
//   mem_error       out  sticky: an access timed out
//   stall_count     out  saturating stalled-cycle counter
module pipe_hazard_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        idex_memRead,
    input  logic [4:0]  idex_rt,
    input  logic [4:0]  ifid_rs,
    input  logic [4:0]  ifid_rt,
    input  logic        branch_taken,
    input  logic        exmem_memAccess,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        exmem_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        memwb_bubble,
    output logic        mem_error,
    output logic [15:0] stall_count
);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  wait_cnt;
    logic        timeout_hit;
    logic        mem_stall;
    logic        lu;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // The last permitted wait cycle completes the access like a ready cycle.
    assign timeout_hit = (state == MEM_WAIT) && (wait_cnt == 8'(TIMEOUT - 1));
    assign mem_stall   = exmem_memAccess & ~mem_ready & ~timeout_hit;
    assign lu          = idex_memRead & (idex_rt != 5'd0) &
                         ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));
    assign mem_req     = exmem_memAccess;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= RUN;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:      if (mem_stall)               state_nxt = MEM_WAIT;
            MEM_WAIT: if (mem_ready | timeout_hit) state_nxt = RUN;
        endcase
    end

    always_comb begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        exmem_en     = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        memwb_bubble = 1'b0;
        if (mem_stall) begin
            // EX is frozen, so branch and load-use handling wait.
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_bubble = 1'b1;
        end else if (branch_taken) begin
            // ID instruction is killed, so a pending load-use is moot.
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (lu) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    // Counts from zero on each entry into MEM_WAIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wait_cnt <= 8'd0;
        else if (state == RUN)
            wait_cnt <= 8'd0;
        else if (state_nxt == MEM_WAIT)
            wait_cnt <= wait_cnt + 8'd1;
    end

    // A ready on the timeout cycle is a normal completion, not an error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            mem_error <= 1'b0;
        else if (timeout_hit & ~mem_ready)
            mem_error <= 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_count <= 16'd0;
        else if (mem_stall | (lu & ~branch_taken))
            stall_count <= sat_inc(stall_count);
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage MIPS core. It generates the enable, flush and bubble signals for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers, covering load-use hazards, taken branches and multi-cycle data-memory accesses. It owns the data-memory request handshake, aborts hung accesses with a timeout, and keeps a saturating stall-cycle counter for performance measurement.

## Interface
- TIMEOUT, 16: maximum MEM_WAIT cycles before an access is force-completed. Legal range 2..255.
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- idex_memRead  in  1  the instruction in EX is a load.
- idex_rt  in  5  destination register of the load in EX.
- ifid_rs, ifid_rt  in  5 each  source registers of the instruction in ID.
- branch_taken  in  1  a taken branch or jump has resolved in EX.
- exmem_memAccess  in  1  the instruction in MEM is a load or store.
- mem_ready  in  1  data memory completes the access this cycle.
- mem_req  out  1  data-memory request.
- pc_en, ifid_en, exmem_en  out  1 each  register load enables.
- ifid_flush, idex_flush  out  1 each  load NOP/zero control on the next edge.
- memwb_bubble  out  1  MEM/WB loads zero control bits (no register write).
- mem_error  out  1  sticky flag: an access timed out.
- stall_count  out  16  saturating count of stalled cycles.

## Operation
- States: RUN, MEM_WAIT. A wait counter `wait_cnt` (8 bits) is cleared on entry to MEM_WAIT.
- mem_req = exmem_memAccess, in both states.
- mem_stall = exmem_memAccess & !mem_ready & !timeout_hit, where timeout_hit = (state == MEM_WAIT) & (wait_cnt == TIMEOUT-1).
- RUN to MEM_WAIT when mem_stall. MEM_WAIT to RUN when mem_ready or timeout_hit. Otherwise the state holds and wait_cnt increments.
- A timeout_hit cycle completes the access exactly like a ready cycle, and sets mem_error on the same edge. mem_error stays set until reset.
- When mem_stall is asserted:
  - pc_en, ifid_en and exmem_en are 0, and the ID/EX register is also held.
  - memwb_bubble is 1.
  - ifid_flush and idex_flush are 0. Branch and load-use handling are suppressed because EX is frozen.
- Load-use stall (lu) = idex_memRead & (idex_rt != 0) & ((idex_rt == ifid_rs) | (idex_rt == ifid_rt)).
  - Under lu: pc_en = 0, ifid_en = 0, idex_flush = 1.
- Taken branch: ifid_flush = 1, idex_flush = 1, pc_en = 1.
  - The branch has priority over lu, since the ID instruction is killed anyway, so pc_en stays 1.
- Priority order: mem_stall, then branch_taken, then lu, then normal. Normal means all enables 1, flushes 0 and memwb_bubble 0.
- stall_count increments on any cycle with mem_stall or (lu & !branch_taken). It holds at 16'hFFFF.

## Timing
- All outputs except mem_error and stall_count are combinational from the state, wait_cnt and the current inputs. There is no registered latency.
- Reset values: state RUN, wait_cnt 0, mem_error 0, stall_count 0.
- With idle inputs after reset: pc_en, ifid_en and exmem_en are 1; the flushes, memwb_bubble and mem_req are 0.
- An access with mem_ready in its first cycle costs 0 stall cycles. Each extra cycle costs 1.
- Maximum access length is 1 RUN cycle plus TIMEOUT MEM_WAIT cycles.
- A load-use hazard costs exactly 1 bubble. On the next cycle the load is in MEM, so lu drops.
- If mem_ready and timeout_hit are both asserted, the access counts as a normal completion and mem_error is not set.
- If branch_taken is asserted during MEM_WAIT, it is ignored that cycle and is acted on in the release cycle, when EX is still holding the branch.
- Reset asserted mid-MEM_WAIT returns the block to RUN immediately. The current access is abandoned and mem_req follows exmem_memAccess.

## Test plan
- Load-use: idex_memRead=1, idex_rt=8, ifid_rs=8 for 1 cycle -> pc_en=0, ifid_en=0, idex_flush=1, and stall_count goes 0 to 1. Repeat with idex_rt=0 -> no stall.
- Branch with hazard: branch_taken=1 together with the lu condition -> ifid_flush=1, idex_flush=1, pc_en=1, and stall_count is unchanged.
- Memory wait: exmem_memAccess=1 with mem_ready low for 3 cycles, then high -> 3 cycles of pc_en=0 and memwb_bubble=1, release on the 4th cycle, stall_count=3.
- Timeout (TIMEOUT=4): mem_ready never asserted -> stalls for 1+3 cycles, advances on the 5th access cycle, mem_error=1 from the following edge and held through later normal traffic.
- Saturation: force 70000 stall cycles -> stall_count=16'hFFFF, which does not wrap.
- Async reset pulse asserted mid-MEM_WAIT, between clock edges -> state RUN, mem_error 0 and stall_count 0 immediately, with no clock edge needed.
